// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stall encodings, FSM states and helpers for the stall controller
package pipe_ctrl_pkg;
   localparam logic STOP       = 1'b1;
   localparam logic NO_STOP    = 1'b0;
   localparam logic RST_ENABLE = 1'b0;
   localparam int   STALL_W    = 6;
   localparam logic [STALL_W-1:0] STALL_NONE    = 6'b000000;
   localparam logic [STALL_W-1:0] STALL_FROM_ID = 6'b000111;
   localparam logic [STALL_W-1:0] STALL_FROM_EX = 6'b001111;
   typedef enum logic [1:0] {
      CTRL_RUN     = 2'b00,
      CTRL_HOLD_ID = 2'b01,
      CTRL_HOLD_EX = 2'b10
   } ctrl_state_e;
   // EX outranks ID; only the 2->3 and 3->4 stop/run boundaries can ever appear
   function automatic logic [STALL_W-1:0] stall_vec(input logic id, input logic ex);
      return ex ? STALL_FROM_EX : id ? STALL_FROM_ID : STALL_NONE;
   endfunction
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall request inputs and stall/statistics outputs of the stall controller
interface pipe_ctrl_if #(parameter int CNT_W = 32);
   logic             stallreq_from_id;
   logic             stallreq_from_ex;
   logic [5:0]       stall;
   logic [1:0]       stall_cause;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] stall_events;
   logic             stall_timeout;
   modport master (
      output stallreq_from_id, stallreq_from_ex,
      input  stall, stall_cause, stall_cycles, stall_events, stall_timeout
   );
   modport slave (
      input  stallreq_from_id, stallreq_from_ex,
      output stall, stall_cause, stall_cycles, stall_events, stall_timeout
   );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: up-counter with synchronous clear that holds once it reaches MAX
module sat_counter
   import pipe_ctrl_pkg::*;
#(
   parameter int           W   = 8,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_cnt
);
   logic [W-1:0] r_cnt;
   // count up on i_inc, stop at MAX, clear takes precedence over increment
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) r_cnt <= '0;
      else if (i_clr)        r_cnt <= '0;
      else if (i_inc && r_cnt != MAX) r_cnt <= r_cnt + 1'b1;
   end
   assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: arbitrates ID/EX stall requests into the pipeline stall vector and tracks stall statistics
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MAX_STALL = 64,
   parameter int CNT_W     = 32
) (
   input logic       clk,
   input logic       rst,
   pipe_ctrl_if.slave bus
);
   localparam logic [15:0] DUR_MAX  = 16'(MAX_STALL);
   localparam logic [15:0] DUR_LAST = 16'(MAX_STALL - 1);
   ctrl_state_e      r_state, w_next;
   logic [5:0]       w_stall;
   logic             w_stalling, w_event, r_timeout;
   logic [15:0]      w_dur;
   logic [CNT_W-1:0] w_cycles, w_events;
   // zero-latency stall vector and next state; every state reacts identically to the requests
   always_comb begin
      w_stall    = (rst == RST_ENABLE) ? STALL_NONE : stall_vec(bus.stallreq_from_id, bus.stallreq_from_ex);
      w_stalling = |w_stall;
      w_event    = w_stalling && r_state == CTRL_RUN;
      w_next     = bus.stallreq_from_ex ? CTRL_HOLD_EX : bus.stallreq_from_id ? CTRL_HOLD_ID : CTRL_RUN;
   end
   // state register; its value is the lagging stall cause
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) r_state <= CTRL_RUN;
      else                   r_state <= w_next;
   end
   // sticky watchdog: set on the edge where the run length reaches MAX_STALL
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE)                   r_timeout <= 1'b0;
      else if (w_stalling && w_dur >= DUR_LAST) r_timeout <= 1'b1;
   end
   sat_counter #(.W(CNT_W)) u_cycles (
      .clk(clk), .rst(rst), .i_inc(w_stalling), .i_clr(1'b0), .o_cnt(w_cycles)
   );
   sat_counter #(.W(CNT_W)) u_events (
      .clk(clk), .rst(rst), .i_inc(w_event), .i_clr(1'b0), .o_cnt(w_events)
   );
   sat_counter #(.W(16), .MAX(DUR_MAX)) u_dur (
      .clk(clk), .rst(rst), .i_inc(w_stalling), .i_clr(!w_stalling), .o_cnt(w_dur)
   );
   assign bus.stall         = w_stall;
   assign bus.stall_cause   = r_state;
   assign bus.stall_cycles  = w_cycles;
   assign bus.stall_events  = w_events;
   assign bus.stall_timeout = r_timeout;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for the stall controller (MAX_STALL=8, CNT_W=4)
module tb_pipe_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   pipe_ctrl_if #(.CNT_W(4)) bus();
   pipe_ctrl #(.MAX_STALL(8), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   // apply requests for one cycle, settle mid-low-phase
   task automatic drive(input logic id, input logic ex);
      @(negedge clk);
      bus.stallreq_from_id = id;
      bus.stallreq_from_ex = ex;
      #1;
   endtask
   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b0;
      bus.stallreq_from_id = 1'b0;
      bus.stallreq_from_ex = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask
   task automatic test_reset();
      @(negedge clk);
      rst = 1'b0;
      bus.stallreq_from_id = 1'b1;
      bus.stallreq_from_ex = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         n_tests++;
         if (bus.stall !== 6'b000000) begin n_fail++; $display("FAIL reset_stall got %b exp 000000", bus.stall); end
      end
      n_tests++;
      if (bus.stall_cause !== 2'b00) begin n_fail++; $display("FAIL reset_cause got %b exp 00", bus.stall_cause); end
      n_tests++;
      if (bus.stall_cycles !== 4'd0 || bus.stall_events !== 4'd0) begin
         n_fail++; $display("FAIL reset_counters got %0d/%0d exp 0/0", bus.stall_cycles, bus.stall_events);
      end
      n_tests++;
      if (bus.stall_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b exp 0", bus.stall_timeout); end
      bus.stallreq_from_id = 1'b0;
      bus.stallreq_from_ex = 1'b0;
      rst = 1'b1;
   endtask
   task automatic test_id_pulse();
      reset_dut();
      drive(1'b1, 1'b0);
      n_tests++;
      if (bus.stall !== 6'b000111 || bus.stall_cause !== 2'b00) begin
         n_fail++; $display("FAIL id_pulse_c0 got %b/%b exp 000111/00", bus.stall, bus.stall_cause);
      end
      drive(1'b0, 1'b0);
      n_tests++;
      if (bus.stall !== 6'b000000 || bus.stall_cause !== 2'b01) begin
         n_fail++; $display("FAIL id_pulse_c1 got %b/%b exp 000000/01", bus.stall, bus.stall_cause);
      end
      drive(1'b0, 1'b0);
      n_tests++;
      if (bus.stall_cause !== 2'b00 || bus.stall_cycles !== 4'd1 || bus.stall_events !== 4'd1) begin
         n_fail++; $display("FAIL id_pulse_c2 got cause %b cyc %0d ev %0d exp 00 1 1", bus.stall_cause, bus.stall_cycles, bus.stall_events);
      end
   endtask
   task automatic test_escalation();
      logic       id_v [7] = '{1, 1, 1, 1, 1, 0, 0};
      logic       ex_v [7] = '{0, 0, 1, 1, 1, 0, 0};
      logic [5:0] e_st [7] = '{6'h07, 6'h07, 6'h0f, 6'h0f, 6'h0f, 6'h00, 6'h00};
      logic [1:0] e_ca [7] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00};
      reset_dut();
      for (int i = 0; i < 7; i++) begin
         drive(id_v[i], ex_v[i]);
         n_tests++;
         if (bus.stall !== e_st[i] || bus.stall_cause !== e_ca[i]) begin
            n_fail++; $display("FAIL escalation_c%0d got %b/%b exp %b/%b", i, bus.stall, bus.stall_cause, e_st[i], e_ca[i]);
         end
      end
      n_tests++;
      if (bus.stall_cycles !== 4'd5 || bus.stall_events !== 4'd1) begin
         n_fail++; $display("FAIL escalation_counts got %0d/%0d exp 5/1", bus.stall_cycles, bus.stall_events);
      end
   endtask
   task automatic test_simultaneous();
      reset_dut();
      drive(1'b1, 1'b1);
      n_tests++;
      if (bus.stall !== 6'b001111) begin n_fail++; $display("FAIL simul_stall got %b exp 001111", bus.stall); end
      drive(1'b1, 1'b0);
      n_tests++;
      if (bus.stall !== 6'b000111 || bus.stall_cause !== 2'b10 || bus.stall_events !== 4'd1) begin
         n_fail++; $display("FAIL simul_c1 got %b/%b ev %0d exp 000111/10 1", bus.stall, bus.stall_cause, bus.stall_events);
      end
      drive(1'b0, 1'b0);
      n_tests++;
      if (bus.stall_cause !== 2'b01 || bus.stall_events !== 4'd1 || bus.stall_cycles !== 4'd2) begin
         n_fail++; $display("FAIL demotion got %b ev %0d cyc %0d exp 01 1 2", bus.stall_cause, bus.stall_events, bus.stall_cycles);
      end
      drive(1'b0, 1'b0);
      n_tests++;
      if (bus.stall_cause !== 2'b00) begin n_fail++; $display("FAIL demotion_run got %b exp 00", bus.stall_cause); end
   endtask
   task automatic test_watchdog();
      reset_dut();
      for (int i = 0; i < 8; i++) drive(1'b0, 1'b1);
      n_tests++;
      if (bus.stall_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_early got %b exp 0", bus.stall_timeout); end
      drive(1'b0, 1'b0);
      n_tests++;
      if (bus.stall_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_rise got %b exp 1", bus.stall_timeout); end
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b0);
      n_tests++;
      if (bus.stall_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_sticky got %b exp 1", bus.stall_timeout); end
      reset_dut();
      #1;
      n_tests++;
      if (bus.stall_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_reset got %b exp 0", bus.stall_timeout); end
      for (int i = 0; i < 7; i++) drive(1'b0, 1'b1);
      drive(1'b0, 1'b0);
      n_tests++;
      if (bus.stall_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_seven got %b exp 0", bus.stall_timeout); end
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1);
      drive(1'b0, 1'b0);
      n_tests++;
      if (bus.stall_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_mixed got %b exp 1", bus.stall_timeout); end
   endtask
   task automatic test_saturation();
      reset_dut();
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b0);
         drive(1'b0, 1'b0);
      end
      n_tests++;
      if (bus.stall_events !== 4'd15 || bus.stall_cycles !== 4'd15) begin
         n_fail++; $display("FAIL saturation got %0d/%0d exp 15/15", bus.stall_events, bus.stall_cycles);
      end
   endtask
   task automatic test_mid_reset();
      reset_dut();
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_tests++;
      if (bus.stall !== 6'b000000) begin n_fail++; $display("FAIL midrst_stall got %b exp 000000", bus.stall); end
      @(negedge clk);
      rst = 1'b1;
      bus.stallreq_from_ex = 1'b0;
      #1;
      n_tests++;
      if (bus.stall_cause !== 2'b00 || bus.stall_cycles !== 4'd0 || bus.stall_events !== 4'd0) begin
         n_fail++; $display("FAIL midrst_state got %b cyc %0d ev %0d exp 00 0 0", bus.stall_cause, bus.stall_cycles, bus.stall_events);
      end
   endtask
   initial begin
      bus.stallreq_from_id = 1'b0;
      bus.stallreq_from_ex = 1'b0;
      test_reset();
      test_id_pulse();
      test_escalation();
      test_simultaneous();
      test_watchdog();
      test_saturation();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
